// File: rtl/dma_mem_bridge_if.sv
// Payload types and main-memory port bundle for the DMA execute stage.
//   dma_mem_bridge_pkg : stage-2 / stage-3 instruction payloads
//   dma_mem_bridge_if  : memory request/response bus
//     master : drives mem_req_valid/we/addr/wdata, receives ready and read response
//     slave  : memory side of the same bus

package dma_mem_bridge_pkg;
  localparam int unsigned MAIN_ADDR_W = 24;
  localparam int unsigned WORD_W      = 18;
  localparam int unsigned SLOT_W      = 4;
  localparam int unsigned CACHE_ADDR_W = 8;

  typedef struct packed {
    logic                    valid;
    logic                    mem_we;
    logic [SLOT_W-1:0]       slot;
    logic [CACHE_ADDR_W-1:0] cache_addr;
    logic [MAIN_ADDR_W-1:0]  main_addr;
  } raw_instr_data_t;

  typedef struct packed {
    raw_instr_data_t     raw_instr_data;
    logic [WORD_W-1:0]   dat;
  } dma_stage_2_instr_t;

  typedef struct packed {
    raw_instr_data_t     raw_instr_data;
    logic [WORD_W-1:0]   dat;
  } dma_stage_3_instr_t;
endpackage

interface dma_mem_bridge_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 18
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/dma_mem_bridge.sv
// DMA execute stage between the dcache read and write ports. Moves one word
// per instruction between the cache and main memory, one transfer in flight.
//   clk, reset  : single clock, synchronous active-high reset
//   freeze      : pipeline freeze, blocks accept and output emission only
//   in_instr    : stage-2 instruction (dcache read port output)
//   in_ready    : bridge can accept in_instr this cycle
//   out_instr   : stage-3 instruction to dcache write port (valid is a pulse)
//   mem         : memory request/response bus (master side)
//   timeout_err : sticky, set when a read response never arrives

module dma_mem_bridge #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   freeze,
  input  dma_mem_bridge_pkg::dma_stage_2_instr_t in_instr,
  output logic                                   in_ready,
  output dma_mem_bridge_pkg::dma_stage_3_instr_t out_instr,
  dma_mem_bridge_if.master                       mem,
  output logic                                   timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned WORD_W = dma_mem_bridge_pkg::WORD_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  state_t                                state;
  dma_mem_bridge_pkg::raw_instr_data_t   raw_q;
  logic [WORD_W-1:0]                     dat_q;
  logic [CNT_W-1:0]                      cnt_q;

  // Accept only when idle and the pipeline is not frozen.
  assign in_ready = (state == IDLE) && !freeze;

  // Request fields come straight from the latched instruction, so they stay
  // stable for as long as the request is pending.
  assign mem.mem_req_valid = (state == REQ);
  assign mem.mem_req_we    = raw_q.mem_we;
  assign mem.mem_req_addr  = ADDR_W'(raw_q.main_addr);
  assign mem.mem_req_wdata = DATA_W'(dat_q);

  // Transfer sequencer and registered stage-3 output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      raw_q       <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      timeout_err <= 1'b0;
      out_instr   <= '0;
      // mem_we=1 keeps the dcache write port disabled while idle.
      out_instr.raw_instr_data.mem_we <= 1'b1;
    end else begin
      out_instr.raw_instr_data.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_instr.raw_instr_data.valid && in_ready) begin
            raw_q <= in_instr.raw_instr_data;
            dat_q <= in_instr.dat;
            state <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            cnt_q <= '0;
            state <= raw_q.mem_we ? DONE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // Response capture ignores freeze so a reply is never dropped.
          if (mem.mem_rsp_valid) begin
            dat_q <= WORD_W'(mem.mem_rsp_rdata);
            state <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (!freeze) begin
            out_instr.raw_instr_data       <= raw_q;
            out_instr.raw_instr_data.valid <= 1'b1;
            out_instr.dat                  <= dat_q;
            state                          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_mem_bridge.sv
// Self-checking bench for dma_mem_bridge: directed scenarios followed by
// randomized traffic, scored against a reference memory model.

module tb_dma_mem_bridge;
  import dma_mem_bridge_pkg::*;

  localparam int unsigned TO = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               freeze;
  dma_stage_2_instr_t in_instr;
  logic               in_ready;
  dma_stage_3_instr_t out_instr;
  logic               timeout_err;

  dma_mem_bridge_if #(.ADDR_W(MAIN_ADDR_W), .DATA_W(WORD_W)) mem_bus ();

  dma_mem_bridge #(.ADDR_W(MAIN_ADDR_W), .DATA_W(WORD_W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .freeze      (freeze),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .out_instr   (out_instr),
    .mem         (mem_bus),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic                   we;
    logic [MAIN_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]      wdata;
  } req_t;

  req_t               req_q[$];
  dma_stage_3_instr_t exp_q[$];
  logic [WORD_W-1:0]  ref_mem[int];
  logic [WORD_W-1:0]  rsp_mem[int];

  // Initial content of never-written memory locations.
  function automatic logic [WORD_W-1:0] fill(input int a);
    return WORD_W'(a * 7 + 341);
  endfunction

  // ---------------- memory responder ----------------
  int   force_ready = 0;  // 0 random, 1 always ready, 2 never ready
  bit   rsp_off = 1'b0;
  bit   inject_late = 1'b0;
  int   rsp_fixed = -1;
  int   rsp_cnt = -1;
  logic [WORD_W-1:0] rsp_pend;
  int   hs_cyc = 0, rsp_cyc = 0, hs_count = 0, rsp_count = 0;

  initial begin
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_rsp_valid = 1'b0;
    mem_bus.mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_bus.mem_rsp_valid = 1'b0;
      if (inject_late) begin
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = WORD_W'($urandom);
        inject_late = 1'b0;
      end else if (rsp_cnt == 0) begin
        mem_bus.mem_rsp_valid = 1'b1;
        mem_bus.mem_rsp_rdata = rsp_pend;
        rsp_cnt   = -1;
        rsp_cyc   = cyc;
        rsp_count++;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end
      if (force_ready == 1)      mem_bus.mem_req_ready = 1'b1;
      else if (force_ready == 2) mem_bus.mem_req_ready = 1'b0;
      else                       mem_bus.mem_req_ready = ($urandom_range(3) != 0);
      // Handshake completes at the coming posedge.
      if (mem_bus.mem_req_valid === 1'b1 && mem_bus.mem_req_ready) begin
        int a;
        hs_cyc = cyc + 1;
        hs_count++;
        if (req_q.size() == 0) begin
          fail_now("req_unexpected");
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_we", 64'(mem_bus.mem_req_we), 64'(r.we));
          chk("req_addr", 64'(mem_bus.mem_req_addr), 64'(r.addr));
          if (r.we) chk("req_wdata", 64'(mem_bus.mem_req_wdata), 64'(r.wdata));
        end
        a = int'(mem_bus.mem_req_addr);
        if (mem_bus.mem_req_we) begin
          rsp_mem[a] = mem_bus.mem_req_wdata;
        end else if (!rsp_off) begin
          rsp_pend = rsp_mem.exists(a) ? rsp_mem[a] : fill(a);
          rsp_cnt  = (rsp_fixed >= 0) ? rsp_fixed : int'($urandom_range(5));
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  int out_count = 0, out_cyc = 0;
  dma_stage_3_instr_t last_out;

  initial begin
    forever begin
      @(negedge clk);
      if (out_instr.raw_instr_data.valid === 1'b1) begin
        out_count++;
        out_cyc  = cyc;
        last_out = out_instr;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: actual=%0h required=none (cycle %0d)", out_instr, cyc);
        end else begin
          chk("out_instr", 64'(out_instr), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- random freeze ----------------
  bit freeze_rand = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (freeze_rand) freeze = ($urandom_range(4) == 0);
    end
  end

  // ---------------- stimulus ----------------
  function automatic dma_stage_2_instr_t mk(input bit we, input int addr, input int dat);
    dma_stage_2_instr_t s;
    s.raw_instr_data.valid      = 1'b1;
    s.raw_instr_data.mem_we     = we;
    s.raw_instr_data.slot       = SLOT_W'($urandom);
    s.raw_instr_data.cache_addr = CACHE_ADDR_W'($urandom);
    s.raw_instr_data.main_addr  = MAIN_ADDR_W'(addr);
    s.dat                       = WORD_W'(dat);
    return s;
  endfunction

  // Present ins until accepted; record what memory and dcache should see.
  task automatic issue(input dma_stage_2_instr_t ins, input bit exp_req, input bit exp_out,
                       output int acc_cyc);
    dma_stage_3_instr_t e;
    int a;
    in_instr = ins;
    acc_cyc  = -1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (in_ready === 1'b1) begin
        acc_cyc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc_cyc < 0) begin
      fail_now("accept_timeout");
    end else begin
      a = int'(ins.raw_instr_data.main_addr);
      if (exp_req) req_q.push_back('{ins.raw_instr_data.mem_we, ins.raw_instr_data.main_addr, ins.dat});
      e.raw_instr_data = ins.raw_instr_data;
      if (ins.raw_instr_data.mem_we) begin
        e.dat = ins.dat;
        if (exp_out) ref_mem[a] = ins.dat;
      end else begin
        e.dat = ref_mem.exists(a) ? ref_mem[a] : fill(a);
      end
      if (exp_out) exp_q.push_back(e);
    end
    @(negedge clk);
    in_instr.raw_instr_data.valid = 1'b0;
    #1;
  endtask

  task automatic wait_out(input int base, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_count > base) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) fail_now(nm);
  endtask

  task automatic wait_req_valid(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_bus.mem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) fail_now(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dma_stage_2_instr_t s;
    dma_stage_3_instr_t rst_exp;
    int acc, base, hs0, rsp0, err_cyc;
    bit ok;

    reset    = 1'b1;
    freeze   = 1'b0;
    in_instr = '0;
    ref_mem[32'h20] = WORD_W'(1337);
    rsp_mem[32'h20] = WORD_W'(1337);
    repeat (3) @(negedge clk);
    #1;

    // Reset state
    rst_exp = '0;
    rst_exp.raw_instr_data.mem_we = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_req_valid", 64'(mem_bus.mem_req_valid), 64'(0));
    chk("rst_timeout_err", 64'(timeout_err), 64'(0));
    chk("rst_out_instr", 64'(out_instr), 64'(rst_exp));
    reset = 1'b0;
    @(negedge clk);

    // Store with latency check
    force_ready = 1;
    s = mk(1'b1, 32'h10, 3423);
    base = out_count;
    issue(s, 1'b1, 1'b1, acc);
    wait_out(base, "store_no_output");
    chk("store_req_latency", 64'(hs_cyc), 64'(acc + 1));
    chk("store_out_latency", 64'(out_cyc), 64'(acc + 2));
    chk("store_out_we", 64'(last_out.raw_instr_data.mem_we), 64'(1));

    // Load with fixed response delay
    rsp_fixed = 3;
    s = mk(1'b0, 32'h20, 0);
    base = out_count;
    issue(s, 1'b1, 1'b1, acc);
    wait_out(base, "load_no_output");
    chk("load_out_latency", 64'(out_cyc), 64'(rsp_cyc + 2));
    chk("load_dat", 64'(last_out.dat), 64'(1337));

    // Back-pressure: request held for 5 cycles
    force_ready = 2;
    s = mk(1'b1, 32'h33, 777);
    base = out_count;
    issue(s, 1'b1, 1'b1, acc);
    wait_req_valid("bp_no_request");
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_req_valid", 64'(mem_bus.mem_req_valid), 64'(1));
      chk("bp_req_addr", 64'(mem_bus.mem_req_addr), 64'(s.raw_instr_data.main_addr));
      chk("bp_req_wdata", 64'(mem_bus.mem_req_wdata), 64'(s.dat));
      @(negedge clk);
      #1;
    end
    force_ready = 1;
    wait_out(base, "bp_no_output");
    repeat (3) @(negedge clk);
    #1;
    chk("bp_one_output", 64'(out_count), 64'(base + 1));

    // Freeze across response arrival
    rsp_fixed = 2;
    hs0  = hs_count;
    rsp0 = rsp_count;
    s = mk(1'b0, 32'h10, 0);
    base = out_count;
    issue(s, 1'b1, 1'b1, acc);
    for (int i = 0; i < 20 && hs_count == hs0; i++) begin
      @(negedge clk);
      #1;
    end
    freeze = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_count > rsp0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) fail_now("frz_no_response");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("frz_no_output", 64'(out_count), 64'(base));
    end
    freeze = 1'b0;
    wait_out(base, "frz_no_output_after_release");
    repeat (3) @(negedge clk);
    #1;
    chk("frz_one_pulse", 64'(out_count), 64'(base + 1));
    rsp_fixed = -1;

    // Response timeout
    rsp_off = 1'b1;
    s = mk(1'b0, 32'h5, 0);
    base = out_count;
    issue(s, 1'b1, 1'b0, acc);
    err_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err === 1'b1) begin
        err_cyc = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (err_cyc < 0) fail_now("to_never_set");
    else chk("to_cycles", 64'(err_cyc - hs_cyc), 64'(TO));
    chk("to_in_ready", 64'(in_ready), 64'(1));
    inject_late = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("to_no_output", 64'(out_count), 64'(base));
    chk("to_sticky", 64'(timeout_err), 64'(1));
    rsp_off = 1'b0;

    // Reset while a request is pending
    force_ready = 2;
    s = mk(1'b1, 32'h44, 99);
    issue(s, 1'b0, 1'b0, acc);
    wait_req_valid("rst_no_request");
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req_dropped", 64'(mem_bus.mem_req_valid), 64'(0));
    chk("rst_in_ready_mid", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_instr.raw_instr_data.valid), 64'(0));
    chk("rst_err_cleared", 64'(timeout_err), 64'(0));
    reset = 1'b0;
    force_ready = 0;
    @(negedge clk);

    // Randomized traffic
    freeze_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      s = mk(1'($urandom), int'($urandom_range(15)), int'($urandom));
      issue(s, 1'b1, 1'b1, acc);
    end
    @(negedge clk);
    freeze_rand = 1'b0;
    freeze = 1'b0;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || req_q.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("drain_out_queue", 64'(exp_q.size()), 64'(0));
    chk("drain_req_queue", 64'(req_q.size()), 64'(0));
    chk("final_no_timeout", 64'(timeout_err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
